// File: rtl/kyber_basemul_pkg.sv
// Shared Kyber constants, FSM state type, Barrett reduction and the
// forward-zetas ROM (17^brv7(i) mod q, standard domain).
package kyber_basemul_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned KYBER_N = 256;

    localparam logic [11:0] Q12           = 12'(KYBER_Q);
    localparam logic [39:0] Q_W           = 40'(KYBER_Q);
    localparam int unsigned BARRETT_SHIFT = 26;
    // floor(2^26 / q); quotient estimate is short by at most one for x < 2^25
    localparam logic [39:0] BARRETT_M     = 40'd20158;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [11:0] barrett_reduce(input logic [24:0] x);
        logic [39:0] x_w;
        logic [39:0] q_est;
        logic [39:0] r;
        x_w   = {15'd0, x};
        q_est = (x_w * BARRETT_M) >> BARRETT_SHIFT;
        r     = x_w - q_est * Q_W;
        if (r >= Q_W) r = r - Q_W;
        return 12'(r);
    endfunction

    function automatic logic [127:0][11:0] gen_zetas();
        logic [127:0][11:0] tbl;
        for (int unsigned i = 0; i < 128; i++) begin
            int unsigned e;
            int unsigned acc;
            int unsigned base;
            e = 0;
            for (int unsigned j = 0; j < 7; j++)
                e = e | (((i >> j) & 1) << (6 - j));
            acc  = 1;
            base = 17;
            for (int unsigned j = 0; j < 7; j++) begin
                if (((e >> j) & 1) != 0) acc = (acc * base) % KYBER_Q;
                base = (base * base) % KYBER_Q;
            end
            tbl[i[6:0]] = 12'(acc);
        end
        return tbl;
    endfunction

    localparam logic [127:0][11:0] ZETAS = gen_zetas();

    function automatic logic [11:0] zeta_rom(input logic [6:0] addr);
        return ZETAS[addr];
    endfunction

endpackage

// File: rtl/kyber_basemul_pair.sv
// One degree-1 basemul pair: S1 holds reduced a0*b0, a1*b1 and cross sum,
// S2 holds reduced a1*b1*z and the cross result; c0 is the final modular add.
module kyber_basemul_pair
    import kyber_basemul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] z,
    output logic [11:0] c0,
    output logic [11:0] c1
);

    logic [23:0] m00, m11, m01, m10, m11z;
    logic [24:0] cross_sum;
    logic [12:0] c0_sum;
    logic [11:0] s1_p00, s1_p11, s1_cross, s1_z;
    logic [11:0] s2_p00, s2_t, s2_cross;

    always_comb begin
        m00       = {12'd0, a0} * {12'd0, b0};
        m11       = {12'd0, a1} * {12'd0, b1};
        m01       = {12'd0, a0} * {12'd0, b1};
        m10       = {12'd0, a1} * {12'd0, b0};
        cross_sum = {1'b0, m01} + {1'b0, m10};
        m11z      = {12'd0, s1_p11} * {12'd0, s1_z};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_p00   <= '0;
            s1_p11   <= '0;
            s1_cross <= '0;
            s1_z     <= '0;
            s2_p00   <= '0;
            s2_t     <= '0;
            s2_cross <= '0;
        end else if (en) begin
            s1_p00   <= barrett_reduce({1'b0, m00});
            s1_p11   <= barrett_reduce({1'b0, m11});
            s1_cross <= barrett_reduce(cross_sum);
            s1_z     <= z;
            s2_p00   <= s1_p00;
            s2_t     <= barrett_reduce({1'b0, m11z});
            s2_cross <= s1_cross;
        end
    end

    always_comb begin
        c0_sum = {1'b0, s2_p00} + {1'b0, s2_t};
        c0     = (c0_sum >= 13'(KYBER_Q)) ? 12'(c0_sum - 13'(KYBER_Q)) : 12'(c0_sum);
        c1     = s2_cross;
    end

endmodule

// File: rtl/kyber_basemul.sv
// NTT-domain pointwise multiply of two polynomials, 8 coefficients per word,
// three-stage pipeline with full-stall backpressure on the output side.
module kyber_basemul
    import kyber_basemul_pkg::*;
#(
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned WORDS   = KYBER_N / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 valid_in,
    input  logic [8*COEFF_W-1:0] a_in,
    input  logic [8*COEFF_W-1:0] b_in,
    output logic                 ready_in,
    output logic [8*COEFF_W-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 done
);

    state_t state, state_nx;
    logic [5:0] in_cnt, out_cnt;
    logic v1, v2;
    logic stall, accept, out_xfer;
    logic [11:0] zeta_lo, zeta_hi;
    logic [11:0] zk [4];
    logic [11:0] pc0 [4];
    logic [11:0] pc1 [4];
    logic [8*COEFF_W-1:0] word_nx;
    logic [8*COEFF_W-1:0] unused_lanes;

    assign unused_lanes = a_in ^ b_in;

    always_comb begin
        stall    = valid_out && !ready_out;
        ready_in = (state == ST_RUN) && (in_cnt < 6'(WORDS)) && !stall;
        accept   = valid_in && ready_in;
        out_xfer = valid_out && ready_out;
        done     = (state == ST_DONE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (out_xfer && out_cnt == 6'(WORDS - 1)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (accept)   in_cnt  <= in_cnt + 6'd1;
                if (out_xfer) out_cnt <= out_cnt + 6'd1;
            end
        end
    end

    // Word w uses zetas[64+2w] for pairs 0/1 and zetas[65+2w] for pairs 2/3.
    always_comb begin
        zeta_lo = zeta_rom({1'b1, in_cnt[4:0], 1'b0});
        zeta_hi = zeta_rom({1'b1, in_cnt[4:0], 1'b1});
        zk[0]   = zeta_lo;
        zk[1]   = Q12 - zeta_lo;
        zk[2]   = zeta_hi;
        zk[3]   = Q12 - zeta_hi;
    end

    for (genvar k = 0; k < 4; k++) begin : g_pair
        kyber_basemul_pair u_pair (
            .clk   (clk),
            .reset (reset),
            .en    (!stall),
            .a0    (a_in[COEFF_W*(2*k)   +: 12]),
            .a1    (a_in[COEFF_W*(2*k+1) +: 12]),
            .b0    (b_in[COEFF_W*(2*k)   +: 12]),
            .b1    (b_in[COEFF_W*(2*k+1) +: 12]),
            .z     (zk[k]),
            .c0    (pc0[k]),
            .c1    (pc1[k])
        );
        assign word_nx[COEFF_W*(2*k)   +: COEFF_W] = COEFF_W'(pc0[k]);
        assign word_nx[COEFF_W*(2*k+1) +: COEFF_W] = COEFF_W'(pc1[k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (!stall) begin
            v1        <= accept;
            v2        <= v1;
            valid_out <= v2;
            data_out  <= word_nx;
        end
    end

endmodule

// File: tb/tb_kyber_basemul.sv
// Directed-vector and model-checked bench for kyber_basemul.
module tb_kyber_basemul;

    localparam int NOSTALL = 100000;

    logic         clk;
    logic         reset;
    logic         start;
    logic         valid_in;
    logic [127:0] a_in;
    logic [127:0] b_in;
    logic         ready_in;
    logic [127:0] data_out;
    logic         valid_out;
    logic         ready_out;
    logic         done;

    int A [256];
    int B [256];
    int zeta_tb [128];
    int nvec;
    int nerr;

    kyber_basemul #(.COEFF_W(16), .WORDS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .valid_in  (valid_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack(input bit sel_b, input int w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[16*i +: 16] = 16'(sel_b ? B[8*w+i] : A[8*w+i]);
        return r;
    endfunction

    function automatic logic [127:0] model_word(input int w);
        logic [127:0] r;
        longint a0, a1, b0, b1, z, c0, c1;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a0 = A[8*w+2*k];
            a1 = A[8*w+2*k+1];
            b0 = B[8*w+2*k];
            b1 = B[8*w+2*k+1];
            z  = zeta_tb[64 + 2*w + k/2];
            if (k % 2 == 1) z = 3329 - z;
            c0 = (a0*b0 + ((a1*b1) % 3329) * z) % 3329;
            c1 = (a0*b1 + a1*b0) % 3329;
            r[32*k +: 16]    = 16'(c0);
            r[32*k+16 +: 16] = 16'(c1);
        end
        return r;
    endfunction

    task automatic run_poly(input int stall_start, input bit rnd,
                            input bit chk_w0, input logic [127:0] exp_w0);
        logic [127:0] expw [32];
        logic [127:0] held;
        bit held_ok;
        int in_idx, out_idx, done_cnt, last_xfer, cyc;
        for (int w = 0; w < 32; w++) expw[w] = model_word(w);
        in_idx = 0; out_idx = 0; done_cnt = 0; last_xfer = -10; held_ok = 0;
        held = '0;
        @(negedge clk);
        valid_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        for (cyc = 0; cyc < 600; cyc++) begin
            start = (cyc == 5);
            if (in_idx < 32 && (!rnd || $urandom_range(3) != 0)) begin
                valid_in = 1'b1;
                a_in     = pack(1'b0, in_idx);
                b_in     = pack(1'b1, in_idx);
            end else begin
                valid_in = 1'b0;
            end
            ready_out = !(cyc >= stall_start && cyc < stall_start + 5) &&
                        (!rnd || $urandom_range(3) != 0);
            #1;
            if (done) begin
                if (done_cnt == 0) check("done_timing", 128'(cyc), 128'(last_xfer + 1));
                done_cnt++;
            end
            if (valid_out && !ready_out) begin
                if (held_ok) check("stall_hold", data_out, held);
                check("stall_ready_in", 128'(ready_in), 128'(0));
                held    = data_out;
                held_ok = 1;
            end else begin
                held_ok = 0;
            end
            if (valid_in && ready_in) in_idx++;
            if (valid_out && ready_out) begin
                if (out_idx < 32) begin
                    check($sformatf("word%0d", out_idx), data_out, expw[out_idx]);
                    if (out_idx == 0 && chk_w0) check("word0_hand", data_out, exp_w0);
                end else begin
                    check("extra_word", 128'(out_idx), 128'(31));
                end
                out_idx++;
                last_xfer = cyc;
            end
            if (done_cnt > 0 && !done) break;
            @(negedge clk);
        end
        start    = 1'b0;
        valid_in = 1'b0;
        check("in_count", 128'(in_idx), 128'(32));
        check("out_count", 128'(out_idx), 128'(32));
        check("done_pulses", 128'(done_cnt), 128'(1));
    endtask

    typedef struct {
        int a0, a1, b0, b1;
        int stall;
        logic [127:0] exp_w0;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int in_idx;
        nvec = 0; nerr = 0;
        reset = 1'b0; start = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        a_in = '0; b_in = '0;

        tbl[0] = '{1, 1, 1, 1, 15,
                   {16'd2, 16'd569, 16'd2, 16'd2762, 16'd2, 16'd3313, 16'd2, 16'd18}};
        tbl[1] = '{3328, 3328, 3328, 3328, NOSTALL,
                   {16'd2, 16'd569, 16'd2, 16'd2762, 16'd2, 16'd3313, 16'd2, 16'd18}};
        tbl[2] = '{0, 1, 0, 1, NOSTALL,
                   {16'd0, 16'd568, 16'd0, 16'd2761, 16'd0, 16'd3312, 16'd0, 16'd17}};
        tbl[3] = '{2, 2, 3, 3, NOSTALL,
                   {16'd12, 16'd85, 16'd12, 16'd3256, 16'd12, 16'd3233, 16'd12, 16'd108}};
        tbl[4] = '{5, 7, 11, 13, 20,
                   {16'd142, 16'd1808, 16'd142, 16'd1631, 16'd142, 16'd1837, 16'd142, 16'd1602}};

        for (int i = 0; i < 128; i++) begin
            int e, v;
            e = 0;
            for (int j = 0; j < 7; j++) if (((i >> j) & 1) != 0) e = e | (1 << (6 - j));
            v = 1;
            for (int j = 0; j < e; j++) v = (v * 17) % 3329;
            zeta_tb[i] = v;
        end

        #1;
        check("rst_ready_in", 128'(ready_in), 128'(0));
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_data_out", data_out, 128'(0));
        check("rst_done", 128'(done), 128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < 256; c++) begin
                A[c] = (c % 2 == 0) ? tbl[t].a0 : tbl[t].a1;
                B[c] = (c % 2 == 0) ? tbl[t].b0 : tbl[t].b1;
            end
            run_poly(tbl[t].stall, 1'b0, 1'b1, tbl[t].exp_w0);
        end

        // mid-stream reset after ten accepted words
        for (int c = 0; c < 256; c++) begin
            A[c] = int'($urandom_range(3328));
            B[c] = int'($urandom_range(3328));
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_idx = 0;
        for (int cyc = 0; cyc < 100 && in_idx < 10; cyc++) begin
            valid_in  = 1'b1;
            a_in      = pack(1'b0, in_idx);
            b_in      = pack(1'b1, in_idx);
            ready_out = 1'b1;
            #1;
            if (ready_in) in_idx++;
            if (in_idx < 10) @(negedge clk);
        end
        check("rst_pre_count", 128'(in_idx), 128'(10));
        @(posedge clk);
        #2;
        valid_in = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_valid_out", 128'(valid_out), 128'(0));
        check("midrst_data_out", data_out, 128'(0));
        check("midrst_ready_in", 128'(ready_in), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            valid_in = 1'b1;
            a_in     = pack(1'b0, c);
            b_in     = pack(1'b1, c);
            #1;
            check("idle_valid_out", 128'(valid_out), 128'(0));
            check("idle_ready_in", 128'(ready_in), 128'(0));
        end
        valid_in = 1'b0;
        run_poly(NOSTALL, 1'b0, 1'b0, '0);

        for (int p = 0; p < 100; p++) begin
            for (int c = 0; c < 256; c++) begin
                A[c] = int'($urandom_range(3328));
                B[c] = int'($urandom_range(3328));
            end
            run_poly(NOSTALL, 1'b1, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
